// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit word-addressed memory between the CPU's
// instruction-fetch port and its data port. Only one transaction is in flight
// at a time. Data accesses win arbitration, except that a fetch waiting behind
// STARVE_MAX consecutive data grants is forced through next. Completion is
// reported with a one-cycle ready pulse and registered read data. The global
// pipeline stall is derived combinationally from the requests and ready pulses.
module mem_arbiter #(
    parameter int STARVE_MAX = 4  // 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction-fetch port
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        i_abort,
    output logic        i_ready,
    output logic [15:0] i_rdata,
    // data (load/store) port
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ready,
    output logic [15:0] d_rdata,
    // memory side
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    // pipeline stall
    output logic        stall
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_starve_cnt;
    logic        r_abort;
    logic        r_mem_en;
    logic        r_mem_wr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_i_ready;
    logic        r_d_ready;
    logic [15:0] r_i_rdata;
    logic [15:0] r_d_rdata;

    logic        w_idle;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_done_i;
    logic        w_done_d;
    logic        w_drop_i;

    // Arbitration: data wins unless the pending fetch has waited out its quota.
    assign w_idle    = (r_state == S_IDLE);
    assign w_grant_d = w_idle & d_req & (~i_req | (r_starve_cnt != STARVE_LIM));
    assign w_grant_i = w_idle & i_req & ~w_grant_d;

    // Completion edges; an abort seen on the completion edge itself also counts.
    assign w_done_i  = (r_state == S_BUSY_I) & mem_valid;
    assign w_done_d  = (r_state == S_BUSY_D) & mem_valid;
    assign w_drop_i  = r_abort | i_abort;

    // Next-state selection for the IDLE / BUSY_I / BUSY_D controller.
    always_comb begin
        // NOTE: default assignment first so every path assigns the variable and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = S_BUSY_D;
                end else if (w_grant_i) begin
                    w_state_nxt = S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (mem_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and the fetch-abort flag, which lives only while BUSY_I.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
            r_state <= S_IDLE;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state != S_BUSY_I || mem_valid) begin
                r_abort <= 1'b0;
            end else if (i_abort) begin
                r_abort <= 1'b1;
            end
        end
    end

    // Fetch-starvation counter: counts data grants made over a waiting fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_d) begin
            if (!i_req) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != STARVE_LIM) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else if (w_grant_i) begin
            r_starve_cnt <= 4'd0;
        end
    end

    // Memory command: latched on grant and held for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: address/data registers are reset as well because the outputs must read 0 after reset.
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
        end else begin
            r_mem_en <= w_grant_d | w_grant_i;
            if (w_grant_d) begin
                r_mem_wr    <= d_wr;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
            end else if (w_grant_i) begin
                r_mem_wr    <= 1'b0;
                r_mem_addr  <= i_addr;
            end
        end
    end

    // Responses: capture read data and pulse ready for one cycle on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_i_rdata <= 16'h0000;
            r_d_rdata <= 16'h0000;
        end else begin
            r_i_ready <= w_done_i & ~w_drop_i;
            r_d_ready <= w_done_d;
            if (w_done_i && !w_drop_i) begin
                r_i_rdata <= mem_rdata;
            end
            if (w_done_d && !r_mem_wr) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_ready   = r_i_ready;
    assign i_rdata   = r_i_rdata;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;

    assign stall = (i_req & ~r_i_ready) | (d_req & ~r_d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-2 memory model answers each
// issue strobe, a monitor logs every grant address and cycle, and one task
// per scenario drives requests and compares outputs at falling clock edges.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = 16'h0000;
    logic        i_abort = 1'b0;
    logic        i_ready;
    logic [15:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = 16'h0000;
    logic [15:0] d_wdata = 16'h0000;
    logic        d_ready;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_valid = 1'b0;
    logic        stall;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_abort  (i_abort),
        .i_ready  (i_ready),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Preset memory contents, all hand-chosen.
    function automatic logic [15:0] init_val(input logic [7:0] a);
        case (a)
            8'h10:   return 16'hBEEF;
            8'h30:   return 16'hC0DE;
            8'h40:   return 16'hAAAA;
            8'h44:   return 16'h4444;
            8'h50:   return 16'h5050;
            8'h80:   return 16'h5A5A;
            8'h90:   return 16'h9090;
            default: return 16'h0000;
        endcase
    endfunction

    // Memory model: sees the issue strobe mid-cycle, answers LAT cycles later.
    logic [15:0] mem_model [0:255];
    bit          written   [0:255];
    int          mm_cnt = 0;
    logic [15:0] mm_data = 16'h0000;
    always @(negedge clk) begin
        mem_valid = 1'b0;
        if (mm_cnt > 0) begin
            mm_cnt--;
            if (mm_cnt == 0) begin
                mem_valid = 1'b1;
                mem_rdata = mm_data;
            end
        end
        if (mem_en === 1'b1) begin
            mm_cnt = LAT;
            if (mem_wr === 1'b1) begin
                mem_model[mem_addr[7:0]] = mem_wdata;
                written[mem_addr[7:0]]   = 1'b1;
            end
            mm_data = written[mem_addr[7:0]] ? mem_model[mem_addr[7:0]] : init_val(mem_addr[7:0]);
        end
    end

    // Grant monitor.
    logic [15:0] grant_q   [$];
    int          grant_cyc [$];
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            grant_q.push_back(mem_addr);
            grant_cyc.push_back(cyc);
        end
    end

    // Waits for a ready pulse on one port, bounded by max_cyc falling edges.
    task automatic wait_ready(input bit fetch, input int max_cyc, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < max_cyc && !ok) begin
            @(negedge clk);
            cycles++;
            if ((fetch ? i_ready : d_ready) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [15:0] vals [8];
        string       names [8];
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vals  = '{16'(mem_en), 16'(mem_wr), mem_addr, mem_wdata,
                  16'(i_ready), 16'(d_ready), i_rdata, d_rdata};
        names = '{"mem_en", "mem_wr", "mem_addr", "mem_wdata",
                  "i_ready", "d_ready", "i_rdata", "d_rdata"};
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (vals[k] !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_%s: got %h expected 0000", names[k], vals[k]);
            end
        end
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stall_idle: got %b expected 0", stall);
        end
        i_req = 1'b1;
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL reset_stall_follows: got %b expected 1", stall);
        end
        i_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        int cycles;
        bit ok;
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
        @(negedge clk);
        n_vec++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0010 || mem_wr !== 1'b0) begin
            n_err++;
            $display("FAIL load_issue: en=%b addr=%h wr=%b expected en=1 addr=0010 wr=0", mem_en, mem_addr, mem_wr);
        end
        @(negedge clk);
        n_vec++;
        if (mem_en !== 1'b0 || mem_addr !== 16'h0010) begin
            n_err++;
            $display("FAIL load_en_one_cycle: en=%b addr=%h expected en=0 addr=0010", mem_en, mem_addr);
        end
        wait_ready(1'b0, 10, cycles, ok);
        n_vec++;
        if (!ok || cycles + 2 != 4) begin
            n_err++;
            $display("FAIL load_latency: ready_seen=%b cycles=%0d expected ready after 4", ok, cycles + 2);
        end
        n_vec++;
        if (d_rdata !== 16'hBEEF) begin
            n_err++;
            $display("FAIL load_rdata: got %h expected beef", d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if (d_ready !== 1'b0) begin
            n_err++;
            $display("FAIL load_ready_pulse: got %b expected 0", d_ready);
        end
    endtask

    task automatic test_store();
        bit seen = 1'b0;
        bit held_ok = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        @(negedge clk);
        n_vec++;
        if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_wdata !== 16'h1234 || mem_addr !== 16'h0020) begin
            n_err++;
            $display("FAIL store_issue: en=%b wr=%b addr=%h wdata=%h expected 1 1 0020 1234", mem_en, mem_wr, mem_addr, mem_wdata);
        end
        i_abort = 1'b1;  // abort only concerns fetches
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            i_abort = 1'b0;
            if (d_ready === 1'b1) begin
                seen = 1'b1;
            end else if (mem_en !== 1'b0 || mem_wr !== 1'b1 || mem_wdata !== 16'h1234 || mem_addr !== 16'h0020) begin
                held_ok = 1'b0;
            end
        end
        n_vec++;
        if (!held_ok) begin
            n_err++;
            $display("FAIL store_held: wr/wdata/addr not held, now wr=%b wdata=%h addr=%h", mem_wr, mem_wdata, mem_addr);
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL store_ready: got no d_ready expected pulse");
        end
        n_vec++;
        if (d_rdata !== 16'hBEEF) begin
            n_err++;
            $display("FAIL store_rdata_kept: got %h expected beef", d_rdata);
        end
        d_req = 1'b0; d_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_order [10];
        int          base;
        bit          done = 1'b0;
        bit          gap_ok = 1'b1;
        exp_order = '{16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0080,
                      16'h0030, 16'h0030, 16'h0030, 16'h0030, 16'h0080};
        base = grant_q.size();
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0080;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0030;
        for (int k = 0; k < 80 && !done; k++) begin
            @(negedge clk);
            if (grant_q.size() - base == 10 && (i_ready === 1'b1 || d_ready === 1'b1)) begin
                i_req = 1'b0; d_req = 1'b0;
                done = 1'b1;
            end
        end
        n_vec++;
        if (!done || grant_q.size() - base != 10) begin
            n_err++;
            $display("FAIL arb_grant_count: got %0d grants expected 10", grant_q.size() - base);
        end
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (base + k >= grant_q.size()) begin
                n_err++;
                $display("FAIL arb_order[%0d]: got none expected %h", k, exp_order[k]);
            end else if (grant_q[base + k] !== exp_order[k]) begin
                n_err++;
                $display("FAIL arb_order[%0d]: got %h expected %h", k, grant_q[base + k], exp_order[k]);
            end
        end
        for (int k = base + 1; k < grant_cyc.size(); k++) begin
            if (grant_cyc[k] - grant_cyc[k - 1] != LAT + 2) gap_ok = 1'b0;
        end
        n_vec++;
        if (!gap_ok) begin
            n_err++;
            $display("FAIL arb_issue_interval: grants not every %0d cycles", LAT + 2);
        end
        n_vec++;
        if (i_rdata !== 16'h5A5A || d_rdata !== 16'hC0DE) begin
            n_err++;
            $display("FAIL arb_rdata: i=%h d=%h expected 5a5a c0de", i_rdata, d_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int tot = 0;
        int base;
        bit seen = 1'b0;
        bit keep_ok = 1'b1;
        base = grant_q.size();
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0040;
        @(negedge clk); tot++;
        n_vec++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0040) begin
            n_err++;
            $display("FAIL abort_issue: en=%b addr=%h expected 1 0040", mem_en, mem_addr);
        end
        i_abort = 1'b1; i_addr = 16'h0044;
        @(negedge clk); tot++;
        i_abort = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk); tot++;
            if (i_ready === 1'b1) seen = 1'b1;
            else if (i_rdata !== 16'h5A5A) keep_ok = 1'b0;
        end
        n_vec++;
        if (!keep_ok) begin
            n_err++;
            $display("FAIL abort_rdata_kept: i_rdata changed to %h expected 5a5a", i_rdata);
        end
        n_vec++;
        if (!seen || tot != 8) begin
            n_err++;
            $display("FAIL abort_next_fetch_ready: seen=%b at %0d expected ready at 8", seen, tot);
        end
        n_vec++;
        if (i_rdata !== 16'h4444) begin
            n_err++;
            $display("FAIL abort_next_rdata: got %h expected 4444", i_rdata);
        end
        n_vec++;
        if (grant_q.size() - base != 2 || grant_q[base] !== 16'h0040 || grant_q[base + 1] !== 16'h0044) begin
            n_err++;
            $display("FAIL abort_grants: count=%0d expected 2 grants 0040,0044", grant_q.size() - base);
        end
        i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cycles;
        bit ok;
        bit quiet = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
        @(negedge clk);
        n_vec++;
        if (mem_en !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_issue: en=%b expected 1", mem_en);
        end
        @(negedge clk);
        rst_n = 1'b0; d_req = 1'b0;
        #1;
        n_vec++;
        if ({mem_en, mem_wr, i_ready, d_ready} !== 4'b0000 || mem_addr !== 16'h0 ||
            mem_wdata !== 16'h0 || i_rdata !== 16'h0 || d_rdata !== 16'h0) begin
            n_err++;
            $display("FAIL rstmid_clear: en=%b wr=%b addr=%h wdata=%h ir=%b dr=%b ird=%h drd=%h expected all 0",
                     mem_en, mem_wr, mem_addr, mem_wdata, i_ready, d_ready, i_rdata, d_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;  // late mem_valid from the killed access arrives now
        repeat (3) begin
            @(negedge clk);
            if (d_ready !== 1'b0 || mem_en !== 1'b0) quiet = 1'b0;
        end
        n_vec++;
        if (!quiet) begin
            n_err++;
            $display("FAIL rstmid_stale_ignored: d_ready=%b mem_en=%b expected 0 0", d_ready, mem_en);
        end
        d_req = 1'b1; d_addr = 16'h0030;
        wait_ready(1'b0, 10, cycles, ok);
        n_vec++;
        if (!ok || cycles != 4 || d_rdata !== 16'hC0DE) begin
            n_err++;
            $display("FAIL rstmid_next_load: seen=%b cycles=%0d rdata=%h expected 1 4 c0de", ok, cycles, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        int  cycles;
        bit  ok;
        bit  stall_ok = 1'b1;
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0090;
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL stall_fetch_req: got %b expected 1", stall);
        end
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0050;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            #1;
            if (stall !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            if (i_ready === 1'b1) ok = 1'b1;
        end
        i_req = 1'b0;
        #1;
        if (stall !== 1'b1) stall_ok = 1'b0;
        n_vec++;
        if (!ok || i_rdata !== 16'h9090) begin
            n_err++;
            $display("FAIL stall_fetch_done: seen=%b rdata=%h expected 1 9090", ok, i_rdata);
        end
        wait_ready(1'b0, 10, cycles, ok);
        n_vec++;
        if (!stall_ok) begin
            n_err++;
            $display("FAIL stall_while_busy: stall dropped before d_ready expected 1");
        end
        n_vec++;
        if (!ok || stall !== 1'b0 || d_rdata !== 16'h5050) begin
            n_err++;
            $display("FAIL stall_ready_cycle: seen=%b stall=%b rdata=%h expected 1 0 5050", ok, stall, d_rdata);
        end
        d_req = 1'b0;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL stall_no_req: got %b expected 0", stall);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
